// File: rtl/lsu_agu_fsm.sv
// Load/store address-generation FSM for the backend mem stage.
// Accepts one load or store at a time and aligns it to the memory bus lanes.
// Misaligned or oversized requests are rejected without touching the bus.
// The block tracks the outstanding operation until done or timeout, then
// holds a registered response until writeback takes it.
module lsu_agu_fsm #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int BUS_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              ld_index_valid,
    input  logic              ld_index_ready,
    output logic [ADDR_W-1:0] ld_index,
    input  logic              ld_done,
    input  logic [BUS_W-1:0]  ld_rdata,
    output logic              st_index_valid,
    input  logic              st_index_ready,
    output logic [ADDR_W-1:0] st_index,
    output logic [BUS_W-1:0]  st_wdata,
    output logic [BUS_W-1:0]  st_wmask,
    input  logic              st_done,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              resp_timeout
);

    localparam int OFF_W = $clog2(BUS_W / 8);
    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_reg;
    logic              is_load_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic              resp_err_reg;
    logic              resp_timeout_reg;

    logic              accept;
    logic [3:0]        size_bytes;
    logic              req_err;
    logic              issue_ld;
    logic              issue_st;
    logic              fire;
    logic              done_hit;
    logic              timeout_hit;
    logic [OFF_W-1:0]  lane_off;
    logic [OFF_W+2:0]  bit_shift;
    logic [BUS_W-1:0]  ld_shift;
    logic [BUS_W-1:0]  st_lane;
    logic [XLEN-1:0]   ld_keep;
    logic [XLEN-1:0]   ld_fmt;
    logic              ld_sign;

    // Request classification: natural alignment and width must both fit.
    assign accept     = req_valid && (state_reg == S_IDLE) && (req_is_load || req_is_store);
    assign size_bytes = 4'd1 << req_size;
    assign req_err    = (int'(size_bytes) > XLEN / 8) ||
                        ((req_addr[2:0] & 3'(size_bytes - 4'd1)) != 3'd0);

    assign lane_off  = addr_reg[OFF_W-1:0];
    assign bit_shift = {lane_off, 3'b000};

    assign issue_ld    = (state_reg == S_ISSUE) && is_load_reg;
    assign issue_st    = (state_reg == S_ISSUE) && !is_load_reg;
    assign fire        = (issue_ld && ld_index_ready) || (issue_st && st_index_ready);
    assign done_hit    = is_load_reg ? ld_done : st_done;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    assign req_ready      = (state_reg == S_IDLE);
    assign ld_index_valid = issue_ld;
    assign st_index_valid = issue_st;
    assign ld_index       = issue_ld ? (addr_reg >> OFF_W) : '0;
    assign st_index       = issue_st ? (addr_reg >> OFF_W) : '0;
    assign st_wdata       = issue_st ? (BUS_W'(wdata_reg) << bit_shift) : '0;
    assign st_wmask       = issue_st ? (st_lane << bit_shift) : '0;

    assign resp_valid   = (state_reg == S_RESP);
    assign resp_rdata   = resp_rdata_reg;
    assign resp_err     = resp_err_reg;
    assign resp_timeout = resp_timeout_reg;

    assign ld_shift = ld_rdata >> bit_shift;

    // Store byte-lane mask before shifting to the addressed lane.
    always_comb begin
        case (size_reg)
            2'd0:    st_lane = BUS_W'(8'hFF);
            2'd1:    st_lane = BUS_W'(16'hFFFF);
            2'd2:    st_lane = BUS_W'(32'hFFFF_FFFF);
            default: st_lane = BUS_W'(64'hFFFF_FFFF_FFFF_FFFF);
        endcase
    end

    // Load extraction: keep the accessed bytes, then sign- or zero-extend.
    always_comb begin
        ld_keep = '1;
        ld_sign = 1'b0;
        case (size_reg)
            2'd0: begin ld_keep = XLEN'(8'hFF);        ld_sign = ld_shift[7];  end
            2'd1: begin ld_keep = XLEN'(16'hFFFF);     ld_sign = ld_shift[15]; end
            2'd2: begin ld_keep = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
            default: ;
        endcase
        ld_fmt = ld_shift[XLEN-1:0] & ld_keep;
        if (ld_sign && !unsigned_reg) begin
            ld_fmt = ld_fmt | ~ld_keep;
        end
    end

    // Control FSM with latched request and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            is_load_reg      <= 1'b0;
            size_reg         <= 2'd0;
            unsigned_reg     <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            cnt_reg          <= '0;
            resp_rdata_reg   <= '0;
            resp_err_reg     <= 1'b0;
            resp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        is_load_reg  <= req_is_load;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        if (req_err) begin
                            state_reg        <= S_RESP;
                            resp_err_reg     <= 1'b1;
                            resp_rdata_reg   <= '0;
                            resp_timeout_reg <= 1'b0;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (fire) begin
                        state_reg <= S_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                S_WAIT: begin
                    if (done_hit) begin
                        state_reg      <= S_RESP;
                        resp_rdata_reg <= is_load_reg ? ld_fmt : '0;
                    end else if (timeout_hit) begin
                        state_reg        <= S_RESP;
                        resp_timeout_reg <= 1'b1;
                        resp_rdata_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (resp_ready) begin
                        state_reg        <= S_IDLE;
                        resp_rdata_reg   <= '0;
                        resp_err_reg     <= 1'b0;
                        resp_timeout_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_agu_fsm.md
Name: lsu_agu_fsm

Overview:
Parametrised load/store unit for the backend mem stage. It accepts one load or store per handshake from the pipeline, then handles byte-lane alignment, store byte masks and load extraction with sign/zero extension. Misaligned accesses are detected and the block does not issue them. It tracks one outstanding memory operation until done or timeout, then returns a registered response to wb.

Parameters:
XLEN, 64, architectural data width (32 or 64).
ADDR_W, 64, request address width.
BUS_W, 64, memory data bus width in bits (power of 2, >= XLEN); OFF_W = log2(BUS_W/8).
TIMEOUT, 255, max WAIT cycles before abort; 0 disables timeout.

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request ready (state == IDLE)
req_is_load  in  1  load request
req_is_store  in  1  store request (ignored when req_is_load = 1)
req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
req_unsigned  in  1  zero-extend load
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data
ld_index_valid  out  1  load index valid
ld_index_ready  in  1  load index ready
ld_index  out  ADDR_W  req_addr >> OFF_W, zero-filled
ld_done  in  1  load complete
ld_rdata  in  BUS_W  load data
st_index_valid  out  1  store index valid
st_index_ready  in  1  store index ready
st_index  out  ADDR_W  req_addr >> OFF_W, zero-filled
st_wdata  out  BUS_W  lane-shifted store data
st_wmask  out  BUS_W  bit mask, 8 bits per enabled byte
st_done  in  1  store complete
resp_valid  out  1  response valid
resp_ready  in  1  response ready
resp_rdata  out  XLEN  formatted load data (0 for store or error)
resp_err  out  1  misaligned access, or size wider than XLEN
resp_timeout  out  1  WAIT aborted by timeout

Behaviour:
- Reset (synchronous, wins over everything): state IDLE, all outputs 0 except req_ready = 1; latched request and timeout counter cleared. Reset mid-operation abandons the transaction. Any later done is ignored.
- Accept: req_valid & req_ready & (is_load | is_store). A request with neither flag set is consumed as a no-op (stays IDLE, no response). On accept, latch addr, size, unsigned, type and wdata.
- Error check at accept: err if addr[size-1:0] != 0 (H, W, D) or (1 << size) > XLEN/8. With err: state goes to RESP at the next cycle, resp_err = 1, rdata = 0, and no bus request is issued.
- States:
  - IDLE -> ISSUE on accept (no err).
  - ISSUE: drive index_valid plus index/wdata/wmask for the latched type, held stable until fire (valid & ready). On fire go to WAIT and clear the counter.
  - WAIT: matching done (ld_done for a load, st_done for a store) goes to RESP. Otherwise the counter increments; at counter == TIMEOUT-1 (TIMEOUT != 0) go to RESP with resp_timeout = 1 and rdata = 0.
  - RESP: resp_valid = 1 with rdata/err/timeout stable until resp_ready, then go to IDLE.
- Done pulses outside WAIT, or of the wrong type, are ignored. The memory side asserts done no earlier than the cycle after fire.
- Minimum latency (load, ready = 1, done at first WAIT cycle): accept at t, fire at t+1, done at t+2, resp_valid at t+3. Error path: accept at t, resp_valid at t+1.
- Store formatting: off = addr[OFF_W-1:0].
  - st_wdata = zext(wdata) << (off*8).
  - st_wmask = ((1 << (8 << size)) - 1) << (off*8).
  - Both are 0 whenever st_index_valid = 0.
- Load formatting: raw = ld_rdata >> (off*8). Take the low (8 << size) bits, sign-extend to XLEN unless unsigned (D passes through). Capture into the resp_rdata register at done.
- Index outputs are 0 when their valid is 0. Only one of ld/st valid is asserted at any time.
- resp_rdata, resp_err and resp_timeout are 0 outside RESP.

Test Plan:
- lb signed, addr 0x1003, ld_rdata 0x0000_0000_8000_0000, done at first WAIT cycle -> ld_index 0x200, resp_rdata 0xFFFF_FFFF_FFFF_FF80, resp_valid at t+3.
- lhu, addr 0x1006, ld_rdata 0xBEEF_0000_0000_0000 -> resp_rdata 0x0000_0000_0000_BEEF, resp_err 0.
- sw, addr 0x2004, wdata 0x1122_3344_5566_7788 -> st_index 0x400, st_wdata 0x5566_7788_0000_0000, st_wmask 0xFFFF_FFFF_0000_0000; st_done -> resp_rdata 0.
- lw, addr 0x1002 -> ld_index_valid never asserted, resp_err 1 at t+1.
- Backpressure:
  - ld_index_ready low for 3 cycles -> ld_index and valid stable, req_ready 0.
  - resp_ready low for 2 cycles -> resp outputs stable; IDLE on the handshake.
- TIMEOUT = 4, no done:
  - resp_timeout 1 after 4 WAIT cycles; a late ld_done is ignored.
  - Separate run: reset asserted mid-WAIT -> IDLE, req_ready 1 next cycle, all other outputs 0.
